// File: rtl/ioctl_dl_sequencer.sv
// ioctl download sequencer: routes the HPS download stream into ROM
// regions and the DIP bank, and owns core reset and ROM load status.
module ioctl_dl_sequencer #(
    parameter logic [16:0] MAIN_END   = 17'h08000,
    parameter logic [16:0] SND_END    = 17'h0C000,
    parameter logic [16:0] GFX_END    = 17'h14000,
    parameter int unsigned SETTLE_CYC = 1024,
    parameter logic [7:0]  DIP_INDEX  = 8'd254
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        user_reset,
    output logic        main_we,
    output logic        snd_we,
    output logic        gfx_we,
    output logic [16:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic [63:0] dip_sw,
    output logic        core_reset,
    output logic        rom_loaded,
    output logic        rom_error,
    output logic        busy
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DIP, SETTLE} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [16:0]   cnt_q, cnt_d;
    logic          ovr_q, ovr_d;
    logic          ur_q;
    logic          main_we_q, main_we_d;
    logic          snd_we_q, snd_we_d;
    logic          gfx_we_q, gfx_we_d;
    logic [16:0]   dl_addr_q, dl_addr_d;
    logic [7:0]    dl_data_q, dl_data_d;
    logic [63:0]   dip_sw_q, dip_sw_d;
    logic          loaded_q, loaded_d;
    logic          error_q, error_d;
    logic          core_reset_q, core_reset_d;

    logic        rom_start;
    logic        dip_start;
    logic        in_range;
    logic [16:0] a17;

    assign rom_start = ioctl_download && (ioctl_index == 8'd0);
    assign dip_start = ioctl_download && (ioctl_index == DIP_INDEX);
    assign a17       = ioctl_addr[16:0];
    assign in_range  = (ioctl_addr[24:17] == 8'd0) && (a17 < GFX_END);

    // Next-state, region decode, DIP capture and settle counting.
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        cnt_d     = cnt_q;
        ovr_d     = ovr_q;
        main_we_d = 1'b0;
        snd_we_d  = 1'b0;
        gfx_we_d  = 1'b0;
        dl_addr_d = dl_addr_q;
        dl_data_d = dl_data_q;
        dip_sw_d  = dip_sw_q;
        loaded_d  = loaded_q;
        error_d   = error_q;
        unique case (state_q)
            IDLE: begin
                if (rom_start) begin
                    state_d  = LOAD;
                    cnt_d    = 17'd0;
                    ovr_d    = 1'b0;
                    loaded_d = 1'b0;
                    error_d  = 1'b0;
                end else if (user_reset) begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_LD;
                end else if (dip_start) begin
                    state_d = DIP;
                end
            end
            LOAD: begin
                if (ioctl_wr) begin
                    if (in_range) begin
                        cnt_d     = cnt_q + 17'd1;
                        dl_data_d = ioctl_dout;
                        if (a17 < MAIN_END) begin
                            main_we_d = 1'b1;
                            dl_addr_d = a17;
                        end else if (a17 < SND_END) begin
                            snd_we_d  = 1'b1;
                            dl_addr_d = a17 - MAIN_END;
                        end else begin
                            gfx_we_d  = 1'b1;
                            dl_addr_d = a17 - SND_END;
                        end
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
                if (!ioctl_download) begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_LD;
                    loaded_d = (cnt_d == GFX_END) && !ovr_d;
                    error_d  = !loaded_d;
                end
            end
            DIP: begin
                if (ioctl_wr && (ioctl_addr[24:3] == 22'd0)) begin
                    dip_sw_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
                end
                if (!ioctl_download) begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (rom_start) begin
                    state_d  = LOAD;
                    cnt_d    = 17'd0;
                    ovr_d    = 1'b0;
                    loaded_d = 1'b0;
                    error_d  = 1'b0;
                end else if (user_reset || ur_q) begin
                    settle_d = SETTLE_LD;
                end else if (settle_q == '0) begin
                    if (loaded_q) begin
                        state_d = IDLE;
                    end
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            default: begin
                state_d  = SETTLE;
                settle_d = SETTLE_LD;
            end
        endcase
    end

    // Core reset follows the state being entered; DIP keeps the old level.
    always_comb begin
        core_reset_d = 1'b1;
        unique case (state_d)
            IDLE:    core_reset_d = 1'b0;
            DIP:     core_reset_d = core_reset_q;
            default: core_reset_d = 1'b1;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q      <= SETTLE;
            settle_q     <= SETTLE_LD;
            cnt_q        <= 17'd0;
            ovr_q        <= 1'b0;
            ur_q         <= 1'b0;
            main_we_q    <= 1'b0;
            snd_we_q     <= 1'b0;
            gfx_we_q     <= 1'b0;
            dl_addr_q    <= 17'd0;
            dl_data_q    <= 8'd0;
            dip_sw_q     <= 64'd0;
            loaded_q     <= 1'b0;
            error_q      <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            cnt_q        <= cnt_d;
            ovr_q        <= ovr_d;
            ur_q         <= user_reset;
            main_we_q    <= main_we_d;
            snd_we_q     <= snd_we_d;
            gfx_we_q     <= gfx_we_d;
            dl_addr_q    <= dl_addr_d;
            dl_data_q    <= dl_data_d;
            dip_sw_q     <= dip_sw_d;
            loaded_q     <= loaded_d;
            error_q      <= error_d;
            core_reset_q <= core_reset_d;
        end
    end

    assign main_we    = main_we_q;
    assign snd_we     = snd_we_q;
    assign gfx_we     = gfx_we_q;
    assign dl_addr    = dl_addr_q;
    assign dl_data    = dl_data_q;
    assign dip_sw     = dip_sw_q;
    assign core_reset = core_reset_q;
    assign rom_loaded = loaded_q;
    assign rom_error  = error_q;
    assign busy       = (state_q == LOAD);

endmodule

// File: tb/tb_ioctl_dl_sequencer.sv
// Bench for ioctl_dl_sequencer: transaction-level model compared every
// cycle, plus directed literal checks on loads, DIP, and reset timing.
module tb_ioctl_dl_sequencer;

    localparam logic [16:0] T_MAIN = 17'h00800;
    localparam logic [16:0] T_SND  = 17'h00C00;
    localparam logic [16:0] T_GFX  = 17'h01400;
    localparam int          T_SET  = 1024;

    logic        clk;
    logic        rst_n;
    logic        dl;
    logic [7:0]  idx;
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic        ureset;
    logic        main_we, snd_we, gfx_we;
    logic [16:0] dl_addr;
    logic [7:0]  dl_data;
    logic [63:0] dip_sw;
    logic        core_reset, rom_loaded, rom_error, busy;

    int checks = 0;
    int failures = 0;
    int n_main = 0, n_snd = 0, n_gfx = 0;

    ioctl_dl_sequencer #(
        .MAIN_END(T_MAIN), .SND_END(T_SND), .GFX_END(T_GFX),
        .SETTLE_CYC(T_SET), .DIP_INDEX(8'd254)
    ) dut (
        .clk_sys(clk), .reset_n(rst_n),
        .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
        .ioctl_addr(addr), .ioctl_dout(dout), .user_reset(ureset),
        .main_we(main_we), .snd_we(snd_we), .gfx_we(gfx_we),
        .dl_addr(dl_addr), .dl_data(dl_data), .dip_sw(dip_sw),
        .core_reset(core_reset), .rom_loaded(rom_loaded),
        .rom_error(rom_error), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model: a download is a stream of bytes; each byte written while a
    // ROM download was already underway lands in the region holding its
    // absolute address one cycle later, or counts as overrun.
    logic        m_busy = 1'b0, m_dipmode = 1'b0;
    int          m_cnt = 0;
    logic        m_ovr = 1'b0, m_ld = 1'b0, m_err = 1'b0;
    logic [7:0]  m_dip [8];
    logic [2:0]  ex_we;
    logic [16:0] ex_a;
    logic [7:0]  ex_d;
    logic [63:0] ex_dip;

    initial for (int i = 0; i < 8; i++) m_dip[i] = 8'h00;

    always @(posedge clk) begin
        ex_we = 3'b000;
        ex_a  = 17'd0;
        ex_d  = 8'd0;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_dipmode = 1'b0;
            m_cnt = 0;
            m_ovr = 1'b0;
            m_ld = 1'b0;
            m_err = 1'b0;
            for (int i = 0; i < 8; i++) m_dip[i] = 8'h00;
        end else begin
            if (m_busy && wr) begin
                if (int'(addr) >= int'(T_GFX)) begin
                    m_ovr = 1'b1;
                end else begin
                    m_cnt++;
                    ex_d = dout;
                    if (int'(addr) < int'(T_MAIN)) begin
                        ex_we = 3'b100;
                        ex_a  = addr[16:0];
                    end else if (int'(addr) < int'(T_SND)) begin
                        ex_we = 3'b010;
                        ex_a  = 17'(int'(addr) - int'(T_MAIN));
                    end else begin
                        ex_we = 3'b001;
                        ex_a  = 17'(int'(addr) - int'(T_SND));
                    end
                end
            end
            if (m_busy && !dl) begin
                m_ld  = (m_cnt == int'(T_GFX)) && !m_ovr;
                m_err = !m_ld;
            end
            if (m_dipmode && wr && int'(addr) < 8) m_dip[addr[2:0]] = dout;
            if (!m_busy && dl && idx == 8'd0) begin
                m_cnt = 0;
                m_ovr = 1'b0;
                m_ld = 1'b0;
                m_err = 1'b0;
            end
            m_busy    = dl && (idx == 8'd0);
            m_dipmode = dl && (idx == 8'd254);
        end
        for (int i = 0; i < 8; i++) ex_dip[i*8 +: 8] = m_dip[i];
        #2;
        chk("strobe",
            {main_we, snd_we, gfx_we,
             (main_we | snd_we | gfx_we) ? {dl_addr, dl_data} : 25'd0},
            {ex_we, ex_we != 3'b000 ? {ex_a, ex_d} : 25'd0});
        chk("status", {busy, rom_loaded, rom_error}, {m_busy, m_ld, m_err});
        chk("dip_sw", dip_sw, ex_dip);
        if (main_we) n_main++;
        if (snd_we)  n_snd++;
        if (gfx_we)  n_gfx++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input string nm, input int n, input logic v);
        logic ok = 1'b1;
        repeat (n) begin
            tick;
            if (core_reset !== v) ok = 1'b0;
        end
        chk(nm, ok, 1'b1);
    endtask

    task automatic settle_len(output int k);
        k = 0;
        while (core_reset && k < 20000) begin
            tick;
            k++;
        end
    endtask

    task automatic load(input int n, input int gap, input logic hi);
        dl  = 1'b1;
        idx = 8'd0;
        tick;
        for (int i = 0; i < n; i++) begin
            addr = 25'(i);
            dout = 8'(i);
            wr   = 1'b1;
            tick;
            #2;
            if (i == 'h805)
                chk("snd_0x805", {main_we, snd_we, gfx_we, dl_addr, dl_data},
                    {3'b010, 17'd5, 8'h05});
            if (i == 'hC00)
                chk("gfx_0xC00", {main_we, snd_we, gfx_we, dl_addr, dl_data},
                    {3'b001, 17'd0, 8'h00});
            if (i == 'h1400)
                chk("ovr_nostrobe", {main_we, snd_we, gfx_we}, 3'b000);
            wr = 1'b0;
            repeat (gap - 1) tick;
        end
        if (hi) begin
            addr = 25'h0020003;
            dout = 8'h5A;
            wr   = 1'b1;
            tick;
            #2;
            chk("hi_nostrobe", {main_we, snd_we, gfx_we}, 3'b000);
            wr = 1'b0;
        end
        dl = 1'b0;
        tick;
    endtask

    initial begin
        int k;
        logic cr_seen;
        rst_n = 1'b0; dl = 1'b0; idx = 8'd0; wr = 1'b0;
        addr = 25'd0; dout = 8'd0; ureset = 1'b0;
        tick;
        tick;
        chk("rst_strobes", {main_we, snd_we, gfx_we}, 3'b000);
        chk("rst_addr_data", {dl_addr, dl_data}, 25'd0);
        chk("rst_dip", dip_sw, 64'd0);
        chk("rst_status", {rom_loaded, rom_error, busy}, 3'b000);
        chk("rst_core_reset", core_reset, 1'b1);
        rst_n = 1'b1;
        hold("empty_rom_hold", 1500, 1'b1);

        load('h900, 1, 1'b0);
        chk("short_status", {rom_loaded, rom_error}, 2'b01);
        hold("short_hold", 10000, 1'b1);

        load('h1401, 1, 1'b0);
        chk("ovr_status", {rom_loaded, rom_error}, 2'b01);

        load('h1400, 1, 1'b1);
        chk("hi_status", {rom_loaded, rom_error}, 2'b01);

        n_main = 0; n_snd = 0; n_gfx = 0;
        load('h1400, 4, 1'b0);
        chk("main_count", n_main, 'h800);
        chk("snd_count", n_snd, 'h400);
        chk("gfx_count", n_gfx, 'h800);
        chk("good_status", {rom_loaded, rom_error, busy}, 3'b100);
        settle_len(k);
        chk("settle_len", k, T_SET);

        n_main = 0; n_snd = 0; n_gfx = 0;
        cr_seen = 1'b0;
        dl = 1'b1; idx = 8'd254;
        tick;
        cr_seen |= core_reset;
        addr = 25'd1; dout = 8'hC2; wr = 1'b1;
        tick;
        cr_seen |= core_reset;
        wr = 1'b0;
        tick;
        addr = 25'd9; dout = 8'h7F; wr = 1'b1;
        tick;
        cr_seen |= core_reset;
        wr = 1'b0;
        dl = 1'b0;
        tick;
        cr_seen |= core_reset;
        tick;
        cr_seen |= core_reset;
        chk("dip_value", dip_sw, 64'h0000_0000_0000_C200);
        chk("dip_core_reset", cr_seen, 1'b0);
        chk("dip_no_rom", n_main + n_snd + n_gfx, 0);

        k = 0;
        ureset = 1'b1;
        repeat (50) begin
            tick;
            if (core_reset) k++;
        end
        ureset = 1'b0;
        while (core_reset && k < 20000) begin
            tick;
            if (core_reset) k++;
        end
        chk("user_reset_len", k, 50 + T_SET);
        chk("user_reset_loaded", rom_loaded, 1'b1);

        dl = 1'b1; idx = 8'd0;
        tick;
        for (int i = 0; i < 16; i++) begin
            addr = 25'(i); dout = 8'(i); wr = 1'b1;
            tick;
        end
        wr = 1'b0;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        dl = 1'b0;
        chk("midload_status", {rom_loaded, rom_error, busy}, 3'b000);
        chk("midload_dip", dip_sw, 64'd0);
        chk("midload_core_reset", core_reset, 1'b1);
        hold("midload_hold", 2000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ioctl_dl_sequencer.md
Name: ioctl_dl_sequencer

Overview:
- Sequences the HPS ioctl download stream into the core's ROM regions and the DIP switch bank.
- Generates the core's active-high reset around downloads and user resets.
- Sits between hps_io and the game core, replacing ad-hoc download glue in the emu top.
- Owns the ROM-loaded and ROM-error status used for LED and reset gating.

Parameters:
- MAIN_END, 17'h08000: first address past main CPU ROM. Region is 0..MAIN_END-1.
- SND_END, 17'h0C000: first address past sound ROM. Region is MAIN_END..SND_END-1.
- GFX_END, 17'h14000: first address past gfx/PROM data. Region is SND_END..GFX_END-1. Also the total expected size.
- SETTLE_CYC, 1024: cycles core_reset is held after a download or user reset ends.
- DIP_INDEX, 8'd254: ioctl_index value of the DIP download.

Ports:
- clk_sys, in, 1: system clock (40 MHz).
- reset_n, in, 1: synchronous, active-low reset.
- ioctl_download, in, 1: download in progress.
- ioctl_index, in, 8: download target; 0 = ROM.
- ioctl_wr, in, 1: one-cycle byte strobe.
- ioctl_addr, in, 25: byte address.
- ioctl_dout, in, 8: byte data.
- user_reset, in, 1: OSD/button reset request, level.
- main_we, out, 1: write strobe for the main ROM region.
- snd_we, out, 1: write strobe for the sound ROM region.
- gfx_we, out, 1: write strobe for the gfx ROM region.
- dl_addr, out, 17: region-relative byte address.
- dl_data, out, 8: byte data.
- dip_sw, out, 64: DIP bytes; byte n at bits [8n+7:8n].
- core_reset, out, 1: active-high core reset.
- rom_loaded, out, 1: a complete ROM image has been received.
- rom_error, out, 1: the last ROM download ended short or overran.
- busy, out, 1: ROM download active; drives LED_USER.

Behaviour:
- Reset (reset_n=0 at a clk_sys edge):
  - Strobes 0, dl_addr 0, dl_data 0.
  - dip_sw 64'h0, rom_loaded 0, rom_error 0, busy 0.
  - core_reset 1; state SETTLE with settle counter = SETTLE_CYC-1.
- FSM states: IDLE, LOAD, DIP, SETTLE.
  - IDLE: core_reset=0.
    - ioctl_download&&index==0 -> LOAD: clear rom_loaded, rom_error, byte counter.
    - ioctl_download&&index==DIP_INDEX -> DIP.
    - user_reset -> SETTLE.
    - Other indices are ignored; stay in IDLE.
  - LOAD: core_reset=1, busy=1.
    - On ioctl_wr: decode ioctl_addr[16:0] against the region bounds.
    - Register exactly one of main_we/snd_we/gfx_we for one cycle (1-cycle latency from ioctl_wr).
    - dl_addr = ioctl_addr[16:0] minus the region base; dl_data = ioctl_dout, valid in the same cycle as the strobe.
    - An address >= GFX_END, or ioctl_addr[24:17]!=0, produces no strobe and sets an overrun flag.
    - A 17-bit counter counts accepted writes.
    - On ioctl_download falling: rom_loaded = (count==GFX_END && !overrun); rom_error = !rom_loaded. Go to SETTLE with counter reload; busy drops the same cycle.
  - DIP: core_reset unchanged from the prior value (0 if the prior state was IDLE).
    - ioctl_wr with ioctl_addr[24:3]==0 writes dip_sw byte ioctl_addr[2:0], 1-cycle latency. Other addresses are ignored.
    - Leaves to IDLE on ioctl_download falling. DIP writes never touch ROM strobes.
  - SETTLE: core_reset=1.
    - Counter decrements each cycle; at 0 -> IDLE if !user_reset and rom_loaded.
    - Stays in SETTLE while user_reset is high (counter held at reload).
    - Stays in SETTLE indefinitely if !rom_loaded, until the next ROM download. This prevents the core running from empty ROM.
    - ROM download start from SETTLE -> LOAD immediately.
- Priority: a ROM download start beats user_reset beats DIP.
  - A DIP download requested during LOAD is not possible; hps_io serialises downloads.
- Repeated ioctl_wr at the same address: each produces a strobe. The counter counts writes, not unique addresses.
- Reset mid-LOAD: everything returns to reset values, rom_loaded=0, core held in SETTLE until a new full download.
- Back-to-back ioctl_wr on consecutive cycles must be supported with no dropped bytes.

Test Plan:
- ROM load: reset, then download index 0 with 0x14000 bytes, data=addr[7:0], one wr every 4 cycles.
  - Expect main_we 32768 times, snd_we 16384, gfx_we 32768.
  - Byte 0x8005 gives snd_we with dl_addr=5; byte 0xC000 gives gfx_we with dl_addr=0.
  - After the fall: rom_loaded=1, rom_error=0; core_reset deasserts exactly SETTLE_CYC cycles later.
- Short load: download of only 0x9000 bytes -> rom_loaded=0, rom_error=1; core_reset stays 1 for 10000 cycles.
- Overrun: download of 0x14001 bytes -> no strobe for byte 0x14000, rom_error=1.
- DIP: index 254, bytes 8'hC2 at addr 1 and 8'h7F at addr 9.
  - dip_sw[15:8]=C2; addr 9 is ignored; core_reset stays 0 throughout; no ROM strobes.
- User reset: after a good load, user_reset high for 50 cycles -> core_reset high for 50+SETTLE_CYC cycles. Then reset_n low for 1 cycle mid-load -> rom_loaded=0, dip_sw=0.
